// File: rtl/video_control_sequencer_if.sv
// Command bus between the ARM-side register-write producer and the video
// control sequencer.
//   cmd_valid  producer -> sequencer  command present
//   cmd_ready  sequencer -> producer  command accepted when valid && ready
//   cmd_op     producer -> sequencer  formatter opcode
//   cmd_data   producer -> sequencer  opcode payload
interface video_control_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/video_control_sequencer.sv
// video_control_sequencer
// Sole driver of the video formatter control_op/control_data bus. Every
// request becomes a one-cycle op pulse followed by GAP_CYCLES idle cycles
// (op=0, data=0) and one IDLE cycle. Single register-write commands from the
// ARM side are queued and arbitrated against an atomic 8-step mode-set
// sequence (dimensions, max, hsync, vsync, polarity, scale, colormode, vsync
// request); a pending mode sequence always wins and is never interleaved.
//
// Build option: define VIDCTRL_CMD_FIFO_EN for a 2^FIFO_AW-entry command FIFO;
// otherwise a single holding register is used.
//
// Ports
//   m_axis_vid_aclk       clock
//   aresetn               asynchronous active-low reset
//   cmd                   command bus (slave modport)
//   mode_start            one-cycle request to run the mode-set sequence
//   mode_*                mode fields, latched on an accepted mode_start
//   mode_busy             accepted mode_start until sequence done
//   seq_done              one-cycle pulse after the final gap of a sequence
//   control_op/data       formatter control bus
module video_control_sequencer #(
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                            m_axis_vid_aclk,
  input  logic                            aresetn,
  video_control_sequencer_if.slave        cmd,
  input  logic                            mode_start,
  input  logic [11:0]                     mode_width,
  input  logic [11:0]                     mode_height,
  input  logic [15:0]                     mode_h_max,
  input  logic [15:0]                     mode_v_max,
  input  logic [15:0]                     mode_hs_start,
  input  logic [15:0]                     mode_hs_end,
  input  logic [15:0]                     mode_vs_start,
  input  logic [15:0]                     mode_vs_end,
  input  logic                            mode_polarity,
  input  logic [1:0]                      mode_scale,
  input  logic [2:0]                      mode_colormode,
  output logic                            mode_busy,
  output logic                            seq_done,
  output logic [7:0]                      control_op,
  output logic [31:0]                     control_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  step_q, step_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Latched mode fields
  logic [11:0] mw_q, mh_q;
  logic [15:0] hmax_q, vmax_q, hss_q, hse_q, vss_q, vse_q;
  logic        pol_q;
  logic [1:0]  scale_q;
  logic [2:0]  cmode_q;

  logic        mode_accept;
  logic [7:0]  step_op;
  logic [31:0] step_data;

  // Command queue view shared by both build variants
  logic        q_empty;
  logic [39:0] q_head;
  logic        q_pop;
  logic        q_push;

  assign mode_accept = mode_start && !busy_q;
  // Opcode 0 is consumed by the handshake but never stored.
  assign q_push      = cmd.cmd_valid && cmd.cmd_ready && (cmd.cmd_op != 8'd0);

`ifdef VIDCTRL_CMD_FIFO_EN
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [39:0]      fifo_mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             q_full;

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign q_head  = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
  // A pop while full does not open a slot for a same-cycle push.
  assign cmd.cmd_ready = !q_full;

  always_ff @(posedge m_axis_vid_aclk) begin
    if (q_push) fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {cmd.cmd_op, cmd.cmd_data};
  end

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (q_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (q_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
`else
  logic        hold_valid_q;
  logic [39:0] hold_q;
  logic        unused_fifo_aw;

  // FIFO_AW only sizes the FIFO build.
  assign unused_fifo_aw = (FIFO_AW != 0);

  assign q_empty       = !hold_valid_q;
  assign q_head        = hold_q;
  assign cmd.cmd_ready = !hold_valid_q;

  // Push only when empty and pop only when full, so the two never coincide.
  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (q_push) begin
      hold_valid_q <= 1'b1;
      hold_q       <= {cmd.cmd_op, cmd.cmd_data};
    end else if (q_pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      mw_q    <= '0;
      mh_q    <= '0;
      hmax_q  <= '0;
      vmax_q  <= '0;
      hss_q   <= '0;
      hse_q   <= '0;
      vss_q   <= '0;
      vse_q   <= '0;
      pol_q   <= 1'b0;
      scale_q <= '0;
      cmode_q <= '0;
    end else if (mode_accept) begin
      mw_q    <= mode_width;
      mh_q    <= mode_height;
      hmax_q  <= mode_h_max;
      vmax_q  <= mode_v_max;
      hss_q   <= mode_hs_start;
      hse_q   <= mode_hs_end;
      vss_q   <= mode_vs_start;
      vse_q   <= mode_vs_end;
      pol_q   <= mode_polarity;
      scale_q <= mode_scale;
      cmode_q <= mode_colormode;
    end
  end

  always_comb begin
    step_op   = '0;
    step_data = '0;
    case (step_q)
      3'd0: begin step_op = 8'd2;  step_data = {4'b0, mh_q, 4'b0, mw_q}; end
      3'd1: begin step_op = 8'd6;  step_data = {vmax_q, hmax_q};         end
      3'd2: begin step_op = 8'd7;  step_data = {hss_q, hse_q};           end
      3'd3: begin step_op = 8'd8;  step_data = {vss_q, vse_q};           end
      3'd4: begin step_op = 8'd10; step_data = {31'b0, pol_q};           end
      3'd5: begin step_op = 8'd4;  step_data = {30'b0, scale_q};         end
      3'd6: begin step_op = 8'd1;  step_data = {29'b0, cmode_q};         end
      3'd7: begin step_op = 8'd5;  step_data = 32'd1;                    end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    op_d      = op_q;
    data_d    = data_q;
    step_d    = step_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    q_pop     = 1'b0;

    if (mode_accept) busy_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (busy_q) begin
          op_d    = step_op;
          data_d  = step_data;
          last_d  = (step_q == 3'd7);
          step_d  = step_q + 3'd1;
          state_d = ST_EMIT;
        end else if (mode_accept) begin
          // Hold the queue back one cycle so the newly accepted sequence
          // is emitted ahead of any waiting command.
        end else if (!q_empty) begin
          op_d    = q_head[39:32];
          data_d  = q_head[31:0];
          q_pop   = 1'b1;
          last_d  = 1'b0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        op_d      = '0;
        data_d    = '0;
        gap_cnt_d = GAP_LOAD;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (last_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            last_d = 1'b0;
            step_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        op_d    = '0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      op_q      <= '0;
      data_q    <= '0;
      step_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      op_q      <= op_d;
      data_q    <= data_d;
      step_q    <= step_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign control_op   = op_q;
  assign control_data = data_q;
  assign mode_busy    = busy_q;
  assign seq_done     = done_q;

endmodule

// File: tb/tb_video_control_sequencer.sv
// Self-checking bench for video_control_sequencer: expected op/data stream is
// built from the mode-step table and command issue order; a monitor checks
// payload order, one-cycle pulses, op spacing and seq_done timing.
module tb_video_control_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  video_control_sequencer_if cif ();

  logic        mode_start;
  logic [11:0] m_w, m_h;
  logic [15:0] m_hmax, m_vmax, m_hss, m_hse, m_vss, m_vse;
  logic        m_pol;
  logic [1:0]  m_scale;
  logic [2:0]  m_cmode;
  logic        mode_busy, seq_done;
  logic [7:0]  control_op;
  logic [31:0] control_data;

  video_control_sequencer #(.GAP_CYCLES(3), .FIFO_AW(4)) dut (
    .m_axis_vid_aclk (clk),
    .aresetn         (rst_n),
    .cmd             (cif),
    .mode_start      (mode_start),
    .mode_width      (m_w),
    .mode_height     (m_h),
    .mode_h_max      (m_hmax),
    .mode_v_max      (m_vmax),
    .mode_hs_start   (m_hss),
    .mode_hs_end     (m_hse),
    .mode_vs_start   (m_vss),
    .mode_vs_end     (m_vse),
    .mode_polarity   (m_pol),
    .mode_scale      (m_scale),
    .mode_colormode  (m_cmode),
    .mode_busy       (mode_busy),
    .seq_done        (seq_done),
    .control_op      (control_op),
    .control_data    (control_data)
  );

`ifdef VIDCTRL_CMD_FIFO_EN
  localparam int QDEPTH = 16;
`else
  localparam int QDEPTH = 1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and monitor
  logic [39:0] exp_q[$];
  int          op_cyc_q[$];
  int          last_op_cyc = -100;
  logic [7:0]  last_op = '0;
  logic [7:0]  prev_op = '0;
  logic        prev_done = 1'b0;
  int          seq_cnt = 0;
  int          seq_cyc = 0;
  logic [39:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_op     = '0;
      prev_done   = 1'b0;
      last_op_cyc = -100;
    end else begin
      if (control_op == 8'd0) begin
        check_eq("idle_data_zero", 40'(control_data), 40'd0);
      end else begin
        check_eq("op_one_cycle", 40'(prev_op), 40'd0);
        check_eq("op_spacing_min5", 40'((cyc - last_op_cyc) >= 5), 40'd1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_op", {control_op, control_data}, 40'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("op_payload", {control_op, control_data}, mon_e);
        end
        last_op_cyc = cyc;
        last_op     = control_op;
        op_cyc_q.push_back(cyc);
      end
      if (seq_done) begin
        check_eq("seq_done_busy_low", 40'(mode_busy), 40'd0);
        check_eq("seq_done_timing", {last_op, 32'(cyc - last_op_cyc)}, {8'd5, 32'd4});
        check_eq("seq_done_pulse", 40'(prev_done), 40'd0);
        seq_cnt++;
        seq_cyc = cyc;
      end
      prev_op   = control_op;
      prev_done = seq_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [31:0] d, output int acc_cyc);
    logic r;
    bit   acc;
    acc     = 0;
    acc_cyc = -1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = d;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      r       = cif.cmd_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (r) acc = 1;
    end
    cif.cmd_valid = 1'b0;
    if (!acc) check_eq("cmd_accept_timeout", 40'd0, 40'd1);
    else if (op != 8'd0) exp_q.push_back({op, d});
  endtask

  task automatic rand_mode();
    m_w     = 12'($urandom);
    m_h     = 12'($urandom);
    m_hmax  = 16'($urandom);
    m_vmax  = 16'($urandom);
    m_hss   = 16'($urandom);
    m_hse   = 16'($urandom);
    m_vss   = 16'($urandom);
    m_vse   = 16'($urandom);
    m_pol   = 1'($urandom);
    m_scale = 2'($urandom);
    m_cmode = 3'($urandom);
  endtask

  // Expected 8-step mode stream from the current field values
  task automatic add_mode_exp();
    exp_q.push_back({8'd2,  4'b0, m_h, 4'b0, m_w});
    exp_q.push_back({8'd6,  m_vmax, m_hmax});
    exp_q.push_back({8'd7,  m_hss, m_hse});
    exp_q.push_back({8'd8,  m_vss, m_vse});
    exp_q.push_back({8'd10, 31'b0, m_pol});
    exp_q.push_back({8'd4,  30'b0, m_scale});
    exp_q.push_back({8'd1,  29'b0, m_cmode});
    exp_q.push_back({8'd5,  32'd1});
  endtask

  task automatic pulse_mode(output int c);
    mode_start = 1'b1;
    c = cyc;
    tick();
    mode_start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mode_busy) ok = 1;
    end
    if (!ok) check_eq("drain_timeout", 40'(exp_q.size()), 40'd0);
    repeat (6) tick();
  endtask

  task automatic wait_ops(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (op_cyc_q.size() >= n) ok = 1;
    end
    if (!ok) check_eq("op_wait_timeout", 40'(op_cyc_q.size()), 40'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a, c0, s0;
    bit seen;
    logic [7:0] rop;

    rst_n = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_data  = '0;
    mode_start = 1'b0;
    rand_mode();

    repeat (3) begin
      @(negedge clk);
      check_eq("rst_op", 40'(control_op), 40'd0);
      check_eq("rst_busy", 40'(mode_busy), 40'd0);
      check_eq("rst_seq_done", 40'(seq_done), 40'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (20) begin
      @(negedge clk);
      check_eq("idle_op", 40'(control_op), 40'd0);
      check_eq("idle_ready", 40'(cif.cmd_ready), 40'd1);
      check_eq("idle_busy", 40'(mode_busy), 40'd0);
    end
    tick();
    // opcode 0 is swallowed: nothing emitted, ready stays up
    push_cmd(8'd0, 32'hDEADBEEF, a);
    @(negedge clk);
    check_eq("op0_ready", 40'(cif.cmd_ready), 40'd1);
    repeat (10) tick();

    // 2: back-to-back sprite data writes
    op_cyc_q.delete();
    push_cmd(8'd15, 32'h01FF00FF, a0);
    push_cmd(8'd15, 32'h00123456, a);
    push_cmd(8'd15, $urandom, a);
    push_cmd(8'd15, $urandom, a);
    wait_idle();
    check_eq("t2_count", 40'(op_cyc_q.size()), 40'd4);
    if (op_cyc_q.size() == 4) begin
      check_eq("t2_latency", 40'(op_cyc_q[0] - a0), 40'd2);
      for (int i = 1; i < 4; i++)
        check_eq("t2_spacing", 40'(op_cyc_q[i] - op_cyc_q[i-1]), 40'd5);
    end

    // 3: 640x480 mode set
    m_w = 12'd640; m_h = 12'd480; m_hmax = 16'd799; m_vmax = 16'd524;
    m_hss = 16'd656; m_hse = 16'd752; m_vss = 16'd490; m_vse = 16'd492;
    m_pol = 1'b1; m_scale = 2'd0; m_cmode = 3'd2;
    add_mode_exp();
    op_cyc_q.delete();
    s0 = seq_cnt;
    pulse_mode(c0);
    @(negedge clk);
    check_eq("t3_busy_set", 40'(mode_busy), 40'd1);
    wait_idle();
    check_eq("t3_count", 40'(op_cyc_q.size()), 40'd8);
    check_eq("t3_seq_done_cnt", 40'(seq_cnt - s0), 40'd1);
    check_eq("t3_busy_clear", 40'(mode_busy), 40'd0);
    if (op_cyc_q.size() == 8) begin
      check_eq("t3_latency", 40'(op_cyc_q[0] - c0), 40'd2);
      for (int i = 1; i < 8; i++)
        check_eq("t3_spacing", 40'(op_cyc_q[i] - op_cyc_q[i-1]), 40'd5);
    end

    // 4: mode_start and command in the same cycle, then ignored mode_start
    rand_mode();
    add_mode_exp();
    exp_q.push_back({8'd3, 32'h05FF0000});
    op_cyc_q.delete();
    s0 = seq_cnt;
    mode_start    = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 8'd3;
    cif.cmd_data  = 32'h05FF0000;
    @(negedge clk);
    check_eq("t4_ready", 40'(cif.cmd_ready), 40'd1);
    tick();
    mode_start    = 1'b0;
    cif.cmd_valid = 1'b0;
    wait_ops(2);
    rand_mode();
    pulse_mode(c0);
    wait_idle();
    check_eq("t4_count", 40'(op_cyc_q.size()), 40'd9);
    check_eq("t4_seq_done_cnt", 40'(seq_cnt - s0), 40'd1);

    // 5: queue fills while a mode sequence runs
    rand_mode();
    add_mode_exp();
    op_cyc_q.delete();
    pulse_mode(c0);
    for (int i = 0; i < QDEPTH; i++)
      push_cmd(8'($urandom_range(1, 255)), $urandom, a);
    @(negedge clk);
    check_eq("t5_ready_full", 40'(cif.cmd_ready), 40'd0);
    check_eq("t5_busy", 40'(mode_busy), 40'd1);
    wait_idle();
    check_eq("t5_count", 40'(op_cyc_q.size()), 40'(8 + QDEPTH));
    if (op_cyc_q.size() > 8)
      check_eq("t5_after_done", 40'(op_cyc_q[8] > seq_cyc), 40'd1);

    // 6: reset in the gap after mode step 3
    rand_mode();
    add_mode_exp();
    op_cyc_q.delete();
    pulse_mode(c0);
    wait_ops(4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_op", 40'(control_op), 40'd0);
    check_eq("t6_rst_data", 40'(control_data), 40'd0);
    check_eq("t6_rst_busy", 40'(mode_busy), 40'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_ready_after_rst", 40'(cif.cmd_ready), 40'd1);
    repeat (30) begin
      @(negedge clk);
      check_eq("t6_quiet_op", 40'(control_op), 40'd0);
      check_eq("t6_quiet_busy", 40'(mode_busy), 40'd0);
    end
    tick();
    // reset during an emitted op clears the bus immediately
    push_cmd(8'd9, $urandom, a);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (control_op != 8'd0) seen = 1;
    end
    check_eq("t6_emit_seen", 40'(seen), 40'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_emit_rst_op", 40'(control_op), 40'd0);
    check_eq("t6_emit_rst_data", 40'(control_data), 40'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) tick();

    // Random mix of commands and mode sequences
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        rand_mode();
        add_mode_exp();
        s0 = seq_cnt;
        pulse_mode(c0);
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 20)) tick();
          rand_mode();
          pulse_mode(c0);
        end
      end else begin
        case ($urandom_range(0, 5))
          0:       rop = 8'd0;
          1:       rop = 8'($urandom_range(16, 255));
          default: rop = 8'($urandom_range(1, 15));
        endcase
        push_cmd(rop, $urandom, a);
        repeat ($urandom_range(0, 6)) tick();
      end
    end
    wait_idle();
    check_eq("scoreboard_empty", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
